// File: rtl/drp_pkg.sv
// rtl/drp_pkg.sv - shared DRP bus widths and transaction FSM state type
package drp_pkg;

   localparam int DRP_ADDR_WIDTH = 9;
   localparam int DRP_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } drp_state_e;

endpackage

// File: rtl/drp_register_target.sv
// rtl/drp_register_target.sv - DRP slave with R/W control registers and read-only status window
module drp_register_target
   import drp_pkg::*;
#(
   parameter int                                  NUM_REGS  = 16,
   parameter int                                  LATENCY   = 2,
   parameter logic [DRP_ADDR_WIDTH-1:0]           BASE_ADDR = 9'h000,
   parameter logic [NUM_REGS*DRP_DATA_WIDTH-1:0]  REG_INIT  = '0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 drp_en,
   input  logic                                 drp_we,
   input  logic [DRP_ADDR_WIDTH-1:0]            drp_addr,
   input  logic [DRP_DATA_WIDTH-1:0]            drp_di,
   output logic [DRP_DATA_WIDTH-1:0]            drp_do,
   output logic                                 drp_rdy,
   output logic [NUM_REGS*DRP_DATA_WIDTH-1:0]   ctrl_out,
   output logic [NUM_REGS-1:0]                  ctrl_wr,
   input  logic [NUM_REGS*DRP_DATA_WIDTH-1:0]   status_in,
   output logic                                 proto_err,
   output logic [15:0]                          err_count
);

   // WAIT lasts LATENCY-1 cycles; the counter is loaded with LATENCY-2 and
   // WAIT exits when it reads zero. LATENCY==1 skips WAIT entirely.
   localparam int               CNT_W        = 3;
   localparam logic [CNT_W-1:0] CNT_LOAD     = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
   localparam drp_state_e       ACCEPT_STATE = (LATENCY > 1) ? ST_WAIT : ST_ACK;

   drp_state_e                           state_q, state_d;
   logic [CNT_W-1:0]                     cnt_q, cnt_d;
   logic                                 we_q, we_d;
   logic [DRP_ADDR_WIDTH-1:0]            addr_q, addr_d;
   logic [DRP_DATA_WIDTH-1:0]            di_q, di_d;
   logic                                 rdy_q, rdy_d;
   logic [DRP_DATA_WIDTH-1:0]            do_q, do_d;
   logic [NUM_REGS*DRP_DATA_WIDTH-1:0]   ctrl_q, ctrl_d;
   logic [NUM_REGS-1:0]                  ctrl_wr_q, ctrl_wr_d;
   logic                                 proto_err_q, proto_err_d;
   logic [15:0]                          err_count_q, err_count_d;

   // Transaction fields: live inputs while IDLE (needed when LATENCY==1
   // completes on the accept edge), latched copies afterwards.
   logic                                 cur_we;
   logic [DRP_ADDR_WIDTH-1:0]            cur_addr;
   logic [DRP_DATA_WIDTH-1:0]            cur_di;
   logic                                 finish;

   logic [DRP_ADDR_WIDTH:0]              addr_ext;
   logic [DRP_ADDR_WIDTH:0]              offset_ext;
   logic                                 above_base;
   logic                                 hit_ctrl;
   logic                                 hit_status;
   logic [DRP_DATA_WIDTH-1:0]            rd_data;

   // Select the fields of the transaction being decoded this cycle
   always_comb begin
      cur_we   = we_q;
      cur_addr = addr_q;
      cur_di   = di_q;
      if (state_q == ST_IDLE) begin
         cur_we   = drp_we;
         cur_addr = drp_addr;
         cur_di   = drp_di;
      end
   end

   // Address decode and read mux; offset arithmetic is one bit wider so an
   // address below the base can never wrap into the window
   always_comb begin
      addr_ext   = {1'b0, cur_addr};
      offset_ext = addr_ext - {1'b0, BASE_ADDR};
      above_base = (addr_ext >= {1'b0, BASE_ADDR});
      hit_ctrl   = above_base && (offset_ext < (DRP_ADDR_WIDTH+1)'(NUM_REGS));
      hit_status = above_base && !hit_ctrl
                   && (offset_ext < (DRP_ADDR_WIDTH+1)'(2 * NUM_REGS));
      rd_data    = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (hit_ctrl && (offset_ext == (DRP_ADDR_WIDTH+1)'(i))) begin
            rd_data = ctrl_q[DRP_DATA_WIDTH*i +: DRP_DATA_WIDTH];
         end
         if (hit_status && (offset_ext == (DRP_ADDR_WIDTH+1)'(NUM_REGS + i))) begin
            rd_data = status_in[DRP_DATA_WIDTH*i +: DRP_DATA_WIDTH];
         end
      end
   end

   // Next-state: FSM sequencing, completion side effects and violation counting
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      di_d        = di_q;
      ctrl_d      = ctrl_q;
      rdy_d       = 1'b0;
      do_d        = '0;
      ctrl_wr_d   = '0;
      proto_err_d = 1'b0;
      err_count_d = err_count_q;
      finish      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (drp_en) begin
               we_d    = drp_we;
               addr_d  = drp_addr;
               di_d    = drp_di;
               cnt_d   = CNT_LOAD;
               state_d = ACCEPT_STATE;
               finish  = (LATENCY == 1);
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_ACK;
               finish  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Edge entering ACK: sample read data, commit control writes
      if (finish) begin
         rdy_d = 1'b1;
         if (!cur_we) begin
            do_d = rd_data;
         end
         for (int i = 0; i < NUM_REGS; i++) begin
            if (cur_we && hit_ctrl && (offset_ext == (DRP_ADDR_WIDTH+1)'(i))) begin
               ctrl_d[DRP_DATA_WIDTH*i +: DRP_DATA_WIDTH] = cur_di;
               ctrl_wr_d[i] = 1'b1;
            end
         end
      end

      // A request while busy is ignored apart from being flagged and counted
      if (drp_en && (state_q != ST_IDLE)) begin
         proto_err_d = 1'b1;
         if (err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         di_q        <= '0;
         rdy_q       <= 1'b0;
         do_q        <= '0;
         ctrl_q      <= REG_INIT;
         ctrl_wr_q   <= '0;
         proto_err_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         di_q        <= di_d;
         rdy_q       <= rdy_d;
         do_q        <= do_d;
         ctrl_q      <= ctrl_d;
         ctrl_wr_q   <= ctrl_wr_d;
         proto_err_q <= proto_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign drp_do    = do_q;
   assign drp_rdy   = rdy_q;
   assign ctrl_out  = ctrl_q;
   assign ctrl_wr   = ctrl_wr_q;
   assign proto_err = proto_err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_drp_register_target.sv
// tb/tb_drp_register_target.sv - scoreboard bench over five latency/base variants of drp_register_target
module tb_drp_register_target;

   localparam int NI = 5;
   localparam int NR = 16;

   function automatic int lat_of(input int k);
      case (k)
         0:       return 2;
         1:       return 4;
         2:       return 3;
         3:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic logic [8:0] base_of(input int k);
      return (k == 1) ? 9'h1F8 : 9'h000;
   endfunction

   function automatic logic [NR*16-1:0] make_init();
      logic [NR*16-1:0] r;
      for (int i = 0; i < NR; i++) r[16*i +: 16] = 16'hA000 + 16'(i);
      return r;
   endfunction

   localparam logic [NR*16-1:0] INIT = make_init();

   typedef struct {
      int               inst;
      int               due;
      logic             chk_do;
      logic [15:0]      data;
      logic [NR*16-1:0] ctrl;
      logic [NR-1:0]    mask;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              en [NI];
   logic              we;
   logic [8:0]        addr;
   logic [15:0]       di;
   logic [NR*16-1:0]  status_v;
   logic [15:0]       do_w [NI];
   logic              rdy_w [NI];
   logic [NR*16-1:0]  co_w [NI];
   logic [NR-1:0]     wr_w [NI];
   logic              pe_w [NI];
   logic [15:0]       ec_w [NI];

   int                cyc = 0;
   int                n_chk = 0;
   int                n_err = 0;
   int                pe_cnt [NI] = '{default: 0};
   logic              started = 1'b0;
   logic [15:0]       model [NI][NR];
   exp_t              sb [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      drp_register_target #(
         .NUM_REGS  (NR),
         .LATENCY   (lat_of(g)),
         .BASE_ADDR (base_of(g)),
         .REG_INIT  (INIT)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .drp_en    (en[g]),
         .drp_we    (we),
         .drp_addr  (addr),
         .drp_di    (di),
         .drp_do    (do_w[g]),
         .drp_rdy   (rdy_w[g]),
         .ctrl_out  (co_w[g]),
         .ctrl_wr   (wr_w[g]),
         .status_in (status_v),
         .proto_err (pe_w[g]),
         .err_count (ec_w[g])
      );
   end

   task automatic check_eq(input string tag, input logic [NR*16-1:0] act, input logic [NR*16-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) if (pe_w[k] === 1'b1) pe_cnt[k] <= pe_cnt[k] + 1;
   end

   // Scoreboard monitor: instance 4 is free-running and left unchecked here
   always @(negedge clk) begin : mon
      exp_t e;
      if (started && !rst) begin
         for (int k = 0; k < NI - 1; k++) begin
            if (rdy_w[k]) begin
               if (sb.size() == 0) begin
                  check_eq("rdy_unexpected", rdy_w[k], 0);
               end else begin
                  e = sb.pop_front();
                  check_eq("rdy_inst", k, e.inst);
                  check_eq("rdy_cycle", cyc, e.due);
                  if (e.chk_do) check_eq("rdy_do", do_w[k], e.data);
                  check_eq("rdy_ctrl_out", co_w[k], e.ctrl);
                  check_eq("rdy_ctrl_wr", wr_w[k], e.mask);
               end
            end else begin
               check_eq("idle_do", do_w[k], 0);
               check_eq("idle_ctrl_wr", wr_w[k], 0);
            end
         end
      end
   end

   function automatic int dec(input int k, input logic [8:0] a);
      int off;
      off = int'(a) - int'(base_of(k));
      if (off < 0 || off >= 2 * NR) return -1;
      return off;
   endfunction

   function automatic logic [NR*16-1:0] model_vec(input int k);
      logic [NR*16-1:0] v;
      for (int i = 0; i < NR; i++) v[16*i +: 16] = model[k][i];
      return v;
   endfunction

   task automatic model_reset();
      logic [NR*16-1:0] iv;
      iv = INIT;
      for (int k = 0; k < NI; k++)
         for (int i = 0; i < NR; i++) model[k][i] = iv[16*i +: 16];
   endtask

   task automatic push_exp(input int k, input logic w, input logic [8:0] a, input logic [15:0] d);
      exp_t e;
      int   idx;
      idx      = dec(k, a);
      e.inst   = k;
      e.due    = cyc + lat_of(k);
      e.chk_do = !w;
      e.data   = 16'h0000;
      if (!w && idx >= 0 && idx < NR) e.data = model[k][idx];
      if (!w && idx >= NR) e.data = status_v[16*(idx-NR) +: 16];
      e.ctrl   = model_vec(k);
      e.mask   = '0;
      if (w && idx >= 0 && idx < NR) begin
         e.ctrl[16*idx +: 16] = d;
         e.mask[idx] = 1'b1;
      end
      sb.push_back(e);
   endtask

   task automatic wait_done();
      for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
      #1;
      check_eq("txn_done", sb.size(), 0);
      sb.delete();
   endtask

   task automatic txn(input int k, input logic w, input logic [8:0] a, input logic [15:0] d);
      int idx;
      push_exp(k, w, a, d);
      we = w; addr = a; di = d; en[k] = 1'b1;
      @(posedge clk); #1;
      en[k] = 1'b0;
      we = 1'($urandom); addr = 9'($urandom); di = 16'($urandom);
      wait_done();
      idx = dec(k, a);
      if (w && idx >= 0 && idx < NR) model[k][idx] = d;
   endtask

   initial begin
      int c0;
      for (int k = 0; k < NI; k++) en[k] = 1'b0;
      we = 1'b0; addr = '0; di = '0;
      for (int i = 0; i < NR; i++) status_v[16*i +: 16] = (i == 5) ? 16'h1234 : 16'hC000 + 16'(i);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         check_eq("rst_rdy", rdy_w[k], 0);
         check_eq("rst_do", do_w[k], 0);
         check_eq("rst_ctrl_wr", wr_w[k], 0);
         check_eq("rst_proto_err", pe_w[k], 0);
         check_eq("rst_err_count", ec_w[k], 0);
         check_eq("rst_ctrl_out", co_w[k], INIT);
      end
      rst = 1'b0;
      model_reset();
      started = 1'b1;

      // LATENCY=2, base 0: control, status, out-of-range windows
      txn(0, 1'b1, 9'd3,   16'hBEEF);
      txn(0, 1'b0, 9'd3,   16'h0000);
      txn(0, 1'b0, 9'd21,  16'h0000);
      txn(0, 1'b1, 9'd21,  16'hFFFF);
      txn(0, 1'b0, 9'd21,  16'h0000);
      txn(0, 1'b0, 9'h1FF, 16'h0000);
      txn(0, 1'b1, 9'h100, 16'h5A5A);
      txn(0, 1'b0, 9'd31,  16'h0000);
      txn(0, 1'b0, 9'd32,  16'h0000);
      txn(0, 1'b0, 9'd15,  16'h0000);
      txn(0, 1'b1, 9'd15,  16'h0F0F);
      txn(0, 1'b0, 9'd15,  16'h0000);
      txn(0, 1'b0, 9'd0,   16'h0000);

      // LATENCY=4, base 0x1F8: window runs past 511, low addresses stay out of range
      txn(1, 1'b1, 9'h1FA, 16'h5555);
      txn(1, 1'b0, 9'h1FA, 16'h0000);
      txn(1, 1'b0, 9'h000, 16'h0000);
      txn(1, 1'b1, 9'h005, 16'h7777);
      txn(1, 1'b0, 9'h1FF, 16'h0000);

      // LATENCY=4: request re-pulsed in the cycle after accept
      push_exp(1, 1'b0, 9'h1FA, 16'h0000);
      we = 1'b0; addr = 9'h1FA; en[1] = 1'b1;
      @(posedge clk); #1;
      we = 1'b1; addr = 9'h1FA; di = 16'hDEAD;
      @(posedge clk); #1;
      en[1] = 1'b0;
      @(negedge clk);
      check_eq("proto_err_pulse", pe_w[1], 1);
      @(negedge clk);
      check_eq("proto_err_single", pe_w[1], 0);
      wait_done();
      check_eq("err_count_one", ec_w[1], 1);

      // LATENCY=3 write aborted by reset; request during reset is dropped
      we = 1'b1; addr = 9'd0; di = 16'h00AA; en[2] = 1'b1;
      @(posedge clk); #1;
      en[2] = 1'b0;
      rst = 1'b1;
      en[0] = 1'b1; we = 1'b1; addr = 9'd1; di = 16'h1111;
      @(posedge clk); #1;
      rst = 1'b0; en[0] = 1'b0;
      model_reset();
      repeat (6) @(posedge clk);
      #1;
      check_eq("abort_reg0", co_w[2][15:0], 16'hA000);
      check_eq("drop_ctrl_out", co_w[0], INIT);
      check_eq("rst_clears_err", ec_w[1], 0);

      // LATENCY=1: ten back-to-back reads
      c0 = cyc;
      for (int i = 0; i < 10; i++) txn(3, 1'b0, (i < 5) ? 9'(i) : 9'(NR + i), 16'h0000);
      check_eq("b2b_span", cyc - c0, 20);
      check_eq("b2b_no_proto_err", pe_cnt[3], 0);
      check_eq("b2b_err_count", ec_w[3], 0);

      // LATENCY=8: request held high, 8 violations per 9-cycle period
      en[4] = 1'b1;
      repeat (90) @(posedge clk);
      #1;
      check_eq("err_count_80", ec_w[4], 80);
      repeat (73910) @(posedge clk);
      #1;
      en[4] = 1'b0;
      check_eq("err_count_sat", ec_w[4], 16'hFFFF);
      repeat (12) @(posedge clk);
      #1;
      check_eq("proto_err_pulses", pe_cnt[4], 65777);
      check_eq("err_count_hold", ec_w[4], 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
